// File: rtl/ball_pkg.sv
// Shared types, constants and helpers for the ball trajectory engine.
// Positions and speeds are signed fixed point with MULT_SHIFT fraction bits.
package ball_pkg;

  localparam int MULT_SHIFT  = 6;
  localparam int LEVELS      = 4;
  localparam int LEVEL_W     = $clog2(LEVELS);
  localparam int PIX_W       = 11;
  localparam int SIZE_BASE   = 8;
  localparam int BOUNCE_BASE = 160;
  localparam int BOUNCE_STEP = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    POPPING
  } ball_state_t;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic signed [31:0] pos_t;
  typedef logic [PIX_W-1:0]   pix_t;

  // Side length in pixels for a size level: each level doubles the side.
  function automatic pix_t ball_side(input level_t level);
    return pix_t'(SIZE_BASE << level);
  endfunction

  // Upward speed magnitude after a floor bounce; fixed per level so every bounce peaks at the same height.
  function automatic pos_t rebound(input level_t level);
    return pos_t'(BOUNCE_BASE + BOUNCE_STEP * int'(level));
  endfunction

  // Scaled position to pixel coordinate; anything left of / above the frame reads as 0.
  function automatic pix_t pos_to_pix(input pos_t pos);
    return pos[31] ? '0 : pix_t'(pos >>> MULT_SHIFT);
  endfunction

endpackage

// File: rtl/ball_axis_integ.sv
// One axis of ball motion: position/speed register pair with per-frame integration
// and clamp-and-reflect against the 0 and max_pos borders.
// The high border always loads -rebound_speed; for X this is the constant horizontal
// speed, for Y it is the level-dependent floor rebound.
module ball_axis_integ
  import ball_pkg::*;
#(
  parameter bit POP_ON_LOW = 1'b0,
  parameter int ACCEL      = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  input  logic frame,
  input  pos_t load_pos,
  input  pos_t load_speed,
  input  pos_t max_pos,
  input  pos_t rebound_speed,
  output pos_t pos,
  output logic pop_req
);

  pos_t pos_q, speed_q;
  pos_t pos_n, speed_n;
  logic at_low, at_high;

  assign at_low  = (pos_q <= 0) && (speed_q < 0);
  assign at_high = (pos_q >= max_pos) && (speed_q > 0);

  assign pos     = pos_q;
  assign pop_req = POP_ON_LOW && at_low;

  // Next position/speed: spawn load, then border reflection (which overrides the frame step), then integration.
  always_comb begin
    pos_n   = pos_q;
    speed_n = speed_q;
    if (load) begin
      pos_n   = load_pos;
      speed_n = load_speed;
    end else if (run) begin
      if (at_high) begin
        pos_n   = max_pos;
        speed_n = -rebound_speed;
      end else if (at_low) begin
        pos_n   = '0;
        speed_n = -speed_q;
      end else if (frame) begin
        pos_n   = pos_q + speed_q;
        speed_n = speed_q + pos_t'(ACCEL);
      end
    end
  end

  // Position and speed registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q   <= '0;
      speed_q <= '0;
    end else begin
      pos_q   <= pos_n;
      speed_q <= speed_n;
    end
  end

endmodule

// File: rtl/ball_kinematics_ctrl.sv
// Single-ball trajectory engine: spawn, gravity, wall/floor/ceiling bounce,
// hit handling with split request and a timed pop phase.
// Optional macro BALL_CEILING_POP_EN: touching the ceiling while moving up pops
// the ball (no split) instead of reflecting it.
module ball_kinematics_ctrl
  import ball_pkg::*;
#(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int GRAVITY    = 1,
  parameter int X_SPEED    = 64,
  parameter int POP_FRAMES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         startOfFrame,
  input  logic         spawn,
  input  logic [10:0]  spawnX,
  input  logic [10:0]  spawnY,
  input  logic [1:0]   spawnLevel,
  input  logic         spawnDirLeft,
  input  logic         hit,
  output logic [10:0]  topLeftX,
  output logic [10:0]  topLeftY,
  output logic [10:0]  ballSize,
  output logic         active,
  output logic         popping,
  output logic         split,
  output logic [1:0]   splitLevel,
  output logic [10:0]  splitX,
  output logic [10:0]  splitY
);

  localparam int CNT_W = $clog2(POP_FRAMES);

`ifdef BALL_CEILING_POP_EN
  localparam bit CEIL_POP = 1'b1;
`else
  localparam bit CEIL_POP = 1'b0;
`endif

  ball_state_t state_q, state_n;
  level_t      level_q;
  logic [CNT_W-1:0] cnt_q;

  logic load, run, enter_pop, split_n;
  logic x_pop, y_pop, border_pop;
  pos_t x_pos, y_pos;
  pos_t x_max, y_max;
  pos_t x_load, y_load, x_load_speed;
  pix_t side, pix_x, pix_y;

  assign side = ball_side(level_q);
  assign x_max = pos_t'(FRAME_W - int'(side)) <<< MULT_SHIFT;
  assign y_max = pos_t'(FRAME_H - int'(side)) <<< MULT_SHIFT;

  assign x_load       = pos_t'({{(32-PIX_W){1'b0}}, spawnX}) <<< MULT_SHIFT;
  assign y_load       = pos_t'({{(32-PIX_W){1'b0}}, spawnY}) <<< MULT_SHIFT;
  assign x_load_speed = spawnDirLeft ? -pos_t'(X_SPEED) : pos_t'(X_SPEED);

  assign border_pop = (state_q == ACTIVE) && (x_pop || y_pop);

  ball_axis_integ #(
    .POP_ON_LOW (1'b0),
    .ACCEL      (0)
  ) u_axis_x (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .run           (run),
    .frame         (startOfFrame),
    .load_pos      (x_load),
    .load_speed    (x_load_speed),
    .max_pos       (x_max),
    .rebound_speed (pos_t'(X_SPEED)),
    .pos           (x_pos),
    .pop_req       (x_pop)
  );

  ball_axis_integ #(
    .POP_ON_LOW (CEIL_POP),
    .ACCEL      (GRAVITY)
  ) u_axis_y (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .run           (run),
    .frame         (startOfFrame),
    .load_pos      (y_load),
    .load_speed    ('0),
    .max_pos       (y_max),
    .rebound_speed (rebound(level_q)),
    .pos           (y_pos),
    .pop_req       (y_pop)
  );

  // Next-state and control: hit beats motion, spawn only from IDLE, pop phase timed by frames.
  always_comb begin
    state_n   = state_q;
    load      = 1'b0;
    run       = 1'b0;
    enter_pop = 1'b0;
    split_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn) begin
          load    = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (hit) begin
          enter_pop = 1'b1;
          split_n   = (level_q != '0);
          state_n   = POPPING;
        end else if (border_pop) begin
          enter_pop = 1'b1;
          state_n   = POPPING;
        end else begin
          run = 1'b1;
        end
      end
      POPPING: begin
        if (startOfFrame && (cnt_q == '0)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Size level captured at spawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (load) begin
      level_q <= spawnLevel;
    end
  end

  // Pop frame counter: preset on entry, counts down once per frame while popping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (enter_pop) begin
      cnt_q <= CNT_W'(POP_FRAMES - 1);
    end else if ((state_q == POPPING) && startOfFrame && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Split request: one-cycle pulse carrying the popped ball's position and the next smaller level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split      <= 1'b0;
      splitLevel <= '0;
      splitX     <= '0;
      splitY     <= '0;
    end else begin
      split      <= split_n;
      splitLevel <= split_n ? (level_q - level_t'(1)) : '0;
      splitX     <= split_n ? pix_x : '0;
      splitY     <= split_n ? pix_y : '0;
    end
  end

  assign pix_x    = pos_to_pix(x_pos);
  assign pix_y    = pos_to_pix(y_pos);
  assign topLeftX = pix_x;
  assign topLeftY = pix_y;
  assign ballSize = (state_q == IDLE) ? '0 : side;
  assign active   = (state_q == ACTIVE);
  assign popping  = (state_q == POPPING);

endmodule
